// File: rtl/sprite_drawer_if.sv
// Sprite drawer -> VGA adapter pixel write port.
// The drawer is the master; the adapter is the slave.
interface sprite_drawer_if #(
    parameter int COLOUR_W = 3
);
    logic [8:0]          vgaX;
    logic [7:0]          vgaY;
    logic [COLOUR_W-1:0] colour;
    logic                plot;

    modport master (output vgaX, vgaY, colour, plot);
    modport slave  (input  vgaX, vgaY, colour, plot);
endinterface

// File: rtl/sprite_drawer.sv
// Streams a SPRITE_W x SPRITE_H block from the background or character ROM to the VGA port.
// Define SPRITE_TRANSPARENCY_EN to skip KEY_COLOUR pixels when drawing the character.
module sprite_drawer #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int COLOUR_W = 3,
`ifdef SPRITE_TRANSPARENCY_EN
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0,
`endif
    localparam int N  = SPRITE_W * SPRITE_H,
    localparam int AW = $clog2(N)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                drawBG,
    input  logic                drawChar,
    input  logic [8:0]          xCoordinate,
    input  logic [7:0]          yCoordinate,
    output logic [AW-1:0]       charAddr,
    input  logic [COLOUR_W-1:0] charData,
    output logic [16:0]         bgAddr,
    input  logic [COLOUR_W-1:0] bgData,
    sprite_drawer_if.master     vga,
    output logic                doneBG,
    output logic                doneChar
);

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        FLUSH,
        DONE,
        RELEASE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          start;
    logic [8:0]    x0;
    logic [7:0]    y0;
    logic          mode_char;
    logic [AW-1:0] cnt;
    logic [8:0]    px_q;
    logic [7:0]    py_q;
    logic          plot_q;

    logic [9:0]    px;
    logic [8:0]    py;
    logic          pvalid;
    logic [16:0]   lin;

    // One bit of headroom so sprites hanging off the right/bottom edge clip cleanly
    always_comb begin
        px     = {1'b0, x0} + 10'(32'(cnt) % SPRITE_W);
        py     = {1'b0, y0} + 9'(32'(cnt) / SPRITE_W);
        pvalid = (px < 10'd320) && (py < 9'd240);
        lin    = 17'(py) * 17'd320 + 17'(px);
    end

    assign bgAddr   = lin;
    assign charAddr = cnt;

    always_comb begin
        state_n = state;
        start   = 1'b0;
        unique case (state)
            IDLE: begin
                if (drawBG || drawChar) begin
                    state_n = DRAW;
                    start   = 1'b1;
                end
            end
            DRAW: begin
                if (cnt == AW'(N - 1)) state_n = FLUSH;
            end
            FLUSH:   state_n = DONE;
            DONE:    state_n = RELEASE;
            RELEASE: begin
                if (!(mode_char ? drawChar : drawBG)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x0        <= '0;
            y0        <= '0;
            mode_char <= 1'b0;
            cnt       <= '0;
            px_q      <= '0;
            py_q      <= '0;
            plot_q    <= 1'b0;
        end else begin
            if (start) begin
                x0        <= xCoordinate;
                y0        <= yCoordinate;
                mode_char <= !drawBG;
                cnt       <= '0;
            end else if (state == DRAW) begin
                cnt <= cnt + 1'b1;
            end
            if (state == DRAW) begin
                px_q <= px[8:0];
                py_q <= py[7:0];
            end
            plot_q <= (state == DRAW) && pvalid;
        end
    end

    assign vga.vgaX   = px_q;
    assign vga.vgaY   = py_q;
    assign vga.colour = mode_char ? charData : bgData;

`ifdef SPRITE_TRANSPARENCY_EN
    assign vga.plot = plot_q && !(mode_char && (charData == KEY_COLOUR));
`else
    assign vga.plot = plot_q;
`endif

    assign doneBG   = (state == DONE) && !mode_char;
    assign doneChar = (state == DONE) && mode_char;

endmodule

// File: tb/tb_sprite_drawer.sv
// Scoreboard bench for sprite_drawer: stimulus pushes expected pixels/dones,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_sprite_drawer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       drawBG = 1'b0;
    logic       drawChar = 1'b0;
    logic [8:0] xCoordinate = '0;
    logic [7:0] yCoordinate = '0;
    logic [5:0] charAddr;
    logic [2:0] charData;
    logic [16:0] bgAddr;
    logic [2:0] bgData;
    logic       doneBG;
    logic       doneChar;

    sprite_drawer_if vga();

    sprite_drawer dut (
        .clock(clock),
        .reset(reset),
        .drawBG(drawBG),
        .drawChar(drawChar),
        .xCoordinate(xCoordinate),
        .yCoordinate(yCoordinate),
        .charAddr(charAddr),
        .charData(charData),
        .bgAddr(bgAddr),
        .bgData(bgData),
        .vga(vga),
        .doneBG(doneBG),
        .doneChar(doneChar)
    );

    always #5 clock = ~clock;

    logic [2:0] char_rom [64];

    // Ten key pixels at 0,6,..,54; all others non-zero
    initial begin
        for (int i = 0; i < 64; i++)
            char_rom[i] = ((i % 6 == 0) && (i < 60)) ? 3'd0 : 3'((i % 7) + 1);
    end

    always @(posedge clock) begin
        charData <= char_rom[charAddr];
        bgData   <= bgAddr[2:0];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int         cyc;
        int         x;
        int         y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        int cyc;
        bit ch;
    } done_t;

    pix_t  pq[$];
    done_t dq[$];
    pix_t  pe;
    done_t de;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [2:0] pix_colour(input bit ch, input int k, input int px, input int py);
        if (ch) return char_rom[k];
        return 3'((py * 320 + px) % 8);
    endfunction

    task automatic push_draw(input bit ch, input int x, input int y, input int t0,
                             input int nmax, input bit done);
        for (int k = 0; k < nmax; k++) begin
            int px;
            int py;
            logic [2:0] c;
            pix_t e;
            px = x + k % 8;
            py = y + k / 8;
            if (px < 320 && py < 240) begin
                c = pix_colour(ch, k, px, py);
`ifdef SPRITE_TRANSPARENCY_EN
                if (ch && c == 3'd0) continue;
`endif
                e.cyc = t0 + 2 + k;
                e.x   = px;
                e.y   = py;
                e.c   = c;
                pq.push_back(e);
            end
        end
        if (done) begin
            done_t d;
            d.cyc = t0 + 66;
            d.ch  = ch;
            dq.push_back(d);
        end
    endtask

    task automatic req(input bit bg, input bit ch, input int x, input int y,
                       input int nmax, input bit done, output int t0);
        @(negedge clock);
        drawBG      = bg;
        drawChar    = ch;
        xCoordinate = 9'(x);
        yCoordinate = 8'(y);
        t0          = cyc;
        push_draw(!bg, x, y, t0, nmax, done);
    endtask

    // Address checks per cycle; coordinates are disturbed mid-draw on purpose
    task automatic watch(input bit ch, input int x, input int y, input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clock);
            if (i == 5) begin
                xCoordinate = 9'd200;
                yCoordinate = 8'd100;
            end
            if (i <= 64) begin
                int k;
                int px;
                int py;
                k  = i - 1;
                px = x + k % 8;
                py = y + k / 8;
                if (ch) check("charAddr", int'(charAddr), k);
                else if (px < 320 && py < 240) check("bgAddr", int'(bgAddr), py * 320 + px);
            end
        end
    endtask

    always @(negedge clock) begin
        if (vga.plot) begin
            checks++;
            if (pq.size() == 0) begin
                $display("FAIL plot_unexpected: got x=%0d y=%0d at cycle %0d, required no plot",
                         vga.vgaX, vga.vgaY, cyc);
            end else begin
                pe = pq.pop_front();
                if (cyc == pe.cyc && int'(vga.vgaX) == pe.x && int'(vga.vgaY) == pe.y
                    && vga.colour == pe.c)
                    passed++;
                else
                    $display("FAIL pixel: got cyc=%0d x=%0d y=%0d c=%0d, required cyc=%0d x=%0d y=%0d c=%0d",
                             cyc, vga.vgaX, vga.vgaY, vga.colour, pe.cyc, pe.x, pe.y, pe.c);
            end
        end
        if (doneBG || doneChar) begin
            checks++;
            if (dq.size() == 0) begin
                $display("FAIL done_unexpected: got doneBG=%0b doneChar=%0b at cycle %0d, required none",
                         doneBG, doneChar, cyc);
            end else begin
                de = dq.pop_front();
                if (cyc == de.cyc && doneChar == de.ch && doneBG == !de.ch)
                    passed++;
                else
                    $display("FAIL done: got cyc=%0d bg=%0b ch=%0b, required cyc=%0d ch=%0b",
                             cyc, doneBG, doneChar, de.cyc, de.ch);
            end
        end
    end

    initial begin
        int t0;
        int t1;
        for (int i = 0; i < 64; i++) char_rom[i] = ((i % 6 == 0) && (i < 60)) ? 3'd0 : 3'((i % 7) + 1);
        repeat (3) @(negedge clock);
        check("reset_state", int'({vga.plot, vga.vgaX, vga.vgaY, doneBG, doneChar}), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Background patch
        req(1'b1, 1'b0, 95, 221, 64, 1'b1, t0);
        watch(1'b0, 95, 221, 66);
        drawBG = 1'b0;
        repeat (4) @(negedge clock);

        // Character, request held after done
        req(1'b0, 1'b1, 126, 68, 64, 1'b1, t0);
        watch(1'b1, 126, 68, 66);
        repeat (5) @(negedge clock);
        drawChar = 1'b0;
        repeat (4) @(negedge clock);

        // Partial clip at the bottom-right corner
        req(1'b1, 1'b0, 316, 236, 64, 1'b1, t0);
        watch(1'b0, 316, 236, 66);
        drawBG = 1'b0;
        repeat (4) @(negedge clock);

        // Fully off-screen
        req(1'b1, 1'b0, 320, 240, 64, 1'b1, t0);
        watch(1'b0, 320, 240, 66);
        drawBG = 1'b0;
        repeat (4) @(negedge clock);

        // Both requests: BG first, then the still-held char request
        req(1'b1, 1'b1, 40, 30, 64, 1'b1, t0);
        watch(1'b0, 40, 30, 66);
        drawBG = 1'b0;
        t1 = t0 + 68;
        push_draw(1'b1, 200, 100, t1, 64, 1'b1);
        repeat (2) @(negedge clock);
        watch(1'b1, 200, 100, 66);
        drawChar = 1'b0;
        repeat (4) @(negedge clock);

        // Reset in cycle 30 of a draw
        req(1'b1, 1'b0, 10, 10, 29, 1'b0, t0);
        watch(1'b0, 10, 10, 29);
        @(negedge clock);
        reset  = 1'b1;
        drawBG = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        req(1'b1, 1'b0, 50, 50, 64, 1'b1, t0);
        watch(1'b0, 50, 50, 66);
        drawBG = 1'b0;
        repeat (10) @(negedge clock);

        check("pix_queue_empty", pq.size(), 0);
        check("done_queue_empty", dq.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sprite_drawer.md
Name: sprite_drawer

Overview:
Downstream consumer of the sprite movement FSM. On a held drawBG or drawChar request it streams a SPRITE_W x SPRITE_H block of pixels to the VGA adapter write port, with the block's top-left corner at the latched (xCoordinate, yCoordinate). Colours come from the background frame ROM (drawBG) or the character sprite ROM (drawChar). A one-cycle doneBG or doneChar pulse ends each draw.

Parameters:
SPRITE_W, 8, sprite width in pixels
SPRITE_H, 8, sprite height in pixels
COLOUR_W, 3, VGA colour width
KEY_COLOUR, 3'b000, transparent colour in character ROM (used only with optional feature)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
drawBG  in  1  level request: redraw background patch; held until doneBG
drawChar  in  1  level request: draw character sprite; held until doneChar
xCoordinate  in  9  sprite top-left X (0..319 on screen)
yCoordinate  in  8  sprite top-left Y (0..239 on screen)
charAddr  out  6  character ROM address = row*SPRITE_W+col (width = clog2(W*H))
charData  in  COLOUR_W  character ROM data, 1-cycle synchronous latency
bgAddr  out  17  background ROM address = y*320+x
bgData  in  COLOUR_W  background ROM data, 1-cycle synchronous latency
vgaX  out  9  pixel X to VGA adapter
vgaY  out  8  pixel Y to VGA adapter
colour  out  COLOUR_W  pixel colour; combinational mux of bgData/charData by latched mode
plot  out  1  VGA write enable
doneBG  out  1  one-cycle pulse, background patch complete
doneChar  out  1  one-cycle pulse, character complete

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state IDLE; pixel counter 0; vgaX, vgaY 0; plot 0; doneBG, doneChar 0; mode BG.
- Reset mid-draw: return to IDLE, plot 0 the next cycle, no done pulse.
- States: IDLE, DRAW, FLUSH, DONE, RELEASE.
- IDLE: on drawBG or drawChar high, latch x0, y0 and mode, clear cnt, go to DRAW.
  - drawBG has priority if both are high.
- DRAW: cnt runs 0..N-1, with N = SPRITE_W*SPRITE_H, row-major; col = cnt mod W, row = cnt / W.
  - The address for pixel cnt is driven combinationally from cnt, x0 and y0.
  - Each cycle, register px = x0+col, py = y0+row and pvalid into vgaX, vgaY and the plot stage.
  - After cnt = N-1, go to FLUSH.
- FLUSH: plot stage presents pixel N-1; go to DONE.
- Pixel timing: pixel k appears on vgaX/vgaY/plot in the cycle after its address, aligned with the ROM data.
- DONE: pulse doneBG or doneChar (per mode) for exactly one cycle; plot 0; go to RELEASE.
- RELEASE: wait until the request for the latched mode is low, then go to IDLE. This prevents retrigger while the controller leaves its wait state.
- Latency: request sampled at edge 0 gives the first plot in cycle 2 and the done pulse in cycle N+2 (66 for 8x8).
- Width rules: px and py are computed one bit wider (10 and 9 bits).
- Clipping: pvalid = (px < 320) && (py < 240). Clipped pixels are not plotted; bgAddr for clipped pixels is don't-care.
  - A fully off-screen sprite (320, 240), as used at game end, issues no plots and still produces its done pulse at N+2.
- Input stability: xCoordinate and yCoordinate are sampled only at the IDLE->DRAW edge; later changes are ignored.
- New requests arriving in DRAW, FLUSH or DONE are ignored until IDLE.

Optional Feature:
SPRITE_TRANSPARENCY_EN
- Defined: in character mode, plot = plot_stage && (charData != KEY_COLOUR), so background shows through key pixels. BG mode is unaffected.
- Undefined: every on-screen pixel is plotted, including KEY_COLOUR.

Test Plan:
- BG draw at (95,221), bgData = addr[2:0] -> exactly 64 plots.
  - First plot in cycle 2 with vgaX=95, vgaY=221, bgAddr=70815.
  - Last plot at (102,228).
  - doneBG high only in cycle 66; doneChar stays 0.
- Char draw at (126,68), charData = pattern -> charAddr 0..63 in order.
  - Colour matches the ROM word one cycle later.
  - doneChar pulses once in cycle 66.
  - Request held 5 extra cycles after done -> no second draw.
- Clip at (316,236) -> 16 plots (x 316..319, y 236..239); at (320,240) -> 0 plots, done still in cycle 66.
- drawBG and drawChar asserted together -> BG draw, doneBG. After release, drawChar still high -> char draw follows.
- Reset asserted in cycle 30 of a draw -> plot 0 from cycle 31, no done pulse. A new request after release -> full 64-pixel draw.
- With SPRITE_TRANSPARENCY_EN, char ROM has 10 key pixels -> 54 plots. Without the macro -> 64 plots.
